// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : In-order instruction fetch with PC tagging, credit-limited
//            output FIFO and branch-flush discard of stale responses.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h00000013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic        i_pc_valid,
  output logic        o_pc_ready,
  input  logic        i_flush,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_misaligned
);

  localparam int unsigned c_ptr_w = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned c_cnt_w = $clog2(BUF_DEPTH) + 1;
  localparam logic [c_cnt_w:0] c_depth = BUF_DEPTH[c_cnt_w:0];

  // Output FIFO storage and pointers
  logic [31:0]        fifo_inst_q [BUF_DEPTH];
  logic [31:0]        fifo_inst_d [BUF_DEPTH];
  logic [31:0]        fifo_pc_q   [BUF_DEPTH];
  logic [31:0]        fifo_pc_d   [BUF_DEPTH];
  logic               fifo_mis_q  [BUF_DEPTH];
  logic               fifo_mis_d  [BUF_DEPTH];
  logic [c_ptr_w-1:0] fifo_wr_q, fifo_wr_d;
  logic [c_ptr_w-1:0] fifo_rd_q, fifo_rd_d;
  logic [c_cnt_w-1:0] fifo_cnt_q, fifo_cnt_d;

  // Tag queue of PCs awaiting their memory response
  logic [31:0]        tag_q [BUF_DEPTH];
  logic [31:0]        tag_d [BUF_DEPTH];
  logic [c_ptr_w-1:0] tag_wr_q, tag_wr_d;
  logic [c_ptr_w-1:0] tag_rd_q, tag_rd_d;

  logic [c_cnt_w-1:0] outst_q, outst_d;
  logic [c_cnt_w-1:0] drop_q, drop_d;

  logic [c_cnt_w:0]   w_used;
  logic               w_credit;
  logic               w_aligned;
  logic               w_fetch_ok;
  logic               w_acc_aln;
  logic               w_acc_mis;
  logic               w_rsp_drop;
  logic               w_rsp_take;
  logic               w_nonempty;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_push_inst;
  logic [31:0]        w_push_pc;
  logic               w_push_mis;

  // Credits count both outstanding reads and buffered words so a response
  // always has a FIFO slot waiting for it.
  assign w_used     = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign w_credit   = (w_used < c_depth);
  assign w_aligned  = (i_pc[1:0] == 2'b00);
  assign w_fetch_ok = i_pc_valid & w_credit & ~i_flush & ~i_rst;

  assign o_imem_req_valid = w_fetch_ok & w_aligned;
  assign o_imem_addr      = i_pc;
  assign w_acc_aln        = o_imem_req_valid & i_imem_req_ready;
  // A misaligned fault waits for older reads to land so output order is kept.
  assign w_acc_mis        = w_fetch_ok & ~w_aligned & (outst_q == '0);
  assign o_pc_ready       = w_acc_aln | w_acc_mis;

  assign w_rsp_drop = i_imem_rsp_valid & (drop_q != '0);
  assign w_rsp_take = i_imem_rsp_valid & (drop_q == '0);

  assign w_nonempty   = (fifo_cnt_q != '0);
  assign o_inst_valid = w_nonempty & ~i_flush;
  assign w_pop        = o_inst_valid & i_inst_ready;
  assign w_push       = w_rsp_take | w_acc_mis;

  assign w_push_inst = w_rsp_take ? i_imem_rsp_data : NOP_INST;
  assign w_push_pc   = w_rsp_take ? tag_q[tag_rd_q] : i_pc;
  assign w_push_mis  = ~w_rsp_take;

  assign o_inst       = w_nonempty ? fifo_inst_q[fifo_rd_q] : '0;
  assign o_inst_pc    = w_nonempty ? fifo_pc_q[fifo_rd_q]   : '0;
  assign o_misaligned = w_nonempty ? fifo_mis_q[fifo_rd_q]  : 1'b0;

  always_comb begin
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_mis_d  = fifo_mis_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_cnt_d  = fifo_cnt_q;
    tag_d       = tag_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    outst_d     = outst_q;
    drop_d      = drop_q - c_cnt_w'(w_rsp_drop);

    if (i_flush) begin
      // Everything still in flight becomes stale; a response landing this
      // cycle has already been consumed from whichever count it belonged to.
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      outst_d    = '0;
      drop_d     = drop_q - c_cnt_w'(w_rsp_drop) + outst_q - c_cnt_w'(w_rsp_take);
    end else begin
      if (w_acc_aln) begin
        tag_d[tag_wr_q] = i_pc;
        tag_wr_d        = tag_wr_q + c_ptr_w'(1);
      end
      if (w_rsp_take) begin
        tag_rd_d = tag_rd_q + c_ptr_w'(1);
      end
      outst_d = outst_q + c_cnt_w'(w_acc_aln) - c_cnt_w'(w_rsp_take);

      if (w_push) begin
        fifo_inst_d[fifo_wr_q] = w_push_inst;
        fifo_pc_d[fifo_wr_q]   = w_push_pc;
        fifo_mis_d[fifo_wr_q]  = w_push_mis;
        fifo_wr_d              = fifo_wr_q + c_ptr_w'(1);
      end
      if (w_pop) begin
        fifo_rd_d = fifo_rd_q + c_ptr_w'(1);
      end
      fifo_cnt_d = fifo_cnt_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        fifo_mis_q[i]  <= 1'b0;
        tag_q[i]       <= '0;
      end
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_mis_q  <= fifo_mis_d;
      tag_q       <= tag_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_cnt_q  <= fifo_cnt_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
    end
  end

endmodule
`default_nettype wire
